sub9bit_serial: RTL

Bit-serial 9-bit unsigned subtractor/comparator, the inverse of the FMAC datapath's 9-bit adder. It computes a - b, borrow-out, a<b flag and |a-b| over multiple cycles using a single one-bit subtractor cell. It is intended for exponent-difference and alignment-shift computation in the FMAC, where area matters more than latency. Control is a start/busy/done handshake.

---
 rtl/sub9bit_serial_pkg.sv | 13 +
 rtl/sub9bit_serial_if.sv | 28 ++
 rtl/sub9bit_serial_sub_bit_cell.sv | 13 +
 rtl/sub9bit_serial.sv | 130 +++++++++++++
 4 files changed

// File: rtl/sub9bit_serial_pkg.sv
// Shared FMAC definitions: default datapath width and the serial-unit state encoding.
package fmac_pkg;

    localparam int unsigned DEF_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        NEG,
        DONE
    } state_t;

endpackage

// File: rtl/sub9bit_serial_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial subtractor.
interface sub9bit_serial_if
    import fmac_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             a_lt_b;
    logic [WIDTH-1:0] abs_diff;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, a_lt_b, abs_diff
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, a_lt_b, abs_diff
    );

endinterface

// File: rtl/sub9bit_serial_sub_bit_cell.sv
// One-bit full subtractor; counterpart of the FMAC adder bit cell.
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub9bit_serial.sv
// Bit-serial unsigned subtractor/comparator: a-b LSB first, then an optional serial
// two's-complement pass that turns a negative difference into |a-b|.
module sub9bit_serial
    import fmac_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    sub9bit_serial_if.slave bus
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, dreg, absreg;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bout_q, lt_q;
    logic             cell_d, cell_bo;
    logic             neg_bit, neg_c;
    logic             accept, last;
    logic             busy_c, done_c;

    sub_bit_cell u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bo)
    );

    // br doubles as the +1 carry during negation: invert-and-increment, one bit per cycle
    assign neg_bit = ~dreg[0] ^ br;
    assign neg_c   = ~dreg[0] & br;
    assign last    = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SUB;
                end
            end
            SUB: begin
                busy_c = 1'b1;
                if (last) state_nxt = cell_bo ? NEG : DONE;
            end
            NEG: begin
                busy_c = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SUB;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            dreg   <= '0;
            absreg <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            bout_q <= 1'b0;
            lt_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        br  <= 1'b0;
                        cnt <= '0;
                    end
                end
                SUB: begin
                    dreg <= {cell_d, dreg[WIDTH-1:1]};
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    br   <= cell_bo;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        bout_q <= cell_bo;
                        lt_q   <= cell_bo;
                        cnt    <= '0;
                        if (cell_bo) br     <= 1'b1;
                        else         absreg <= {cell_d, dreg[WIDTH-1:1]};
                    end
                end
                NEG: begin
                    // full rotation over WIDTH cycles leaves diff intact
                    dreg   <= {dreg[0], dreg[WIDTH-1:1]};
                    absreg <= {neg_bit, absreg[WIDTH-1:1]};
                    br     <= neg_c;
                    cnt    <= last ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.diff     = dreg;
    assign bus.bout     = bout_q;
    assign bus.a_lt_b   = lt_q;
    assign bus.abs_diff = absreg;

endmodule
